// File: rtl/chirp_profile_sequencer_if.sv
// Configuration and control bundle between the chirp profile sequencer
// and its host, with the generator-facing outputs.
interface chirp_profile_sequencer_if #(
    parameter int N  = 32,
    parameter int P  = 4,
    parameter int BW = 8
);
    localparam int PW = $clog2(P);

    logic              cfg_we;
    logic [PW+2:0]     cfg_addr;
    logic [N-1:0]      cfg_wdata;
    logic [PW:0]       num_profiles;
    logic [BW-1:0]     burst_count;
    logic              start;
    logic              stop;

    logic              gen_rst;
    logic [N-1:0]      chirp_min_ctrl;
    logic [N-1:0]      chirp_max_ctrl;
    logic [N-1:0]      chirp_inc_rate;
    logic [N-1:0]      chirp_div_rate;
    logic [7:0]        chirp_delay;
    logic              chirp_reverse;
    logic [PW-1:0]     cur_profile;
    logic              busy;
    logic              done;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, num_profiles,
        output burst_count, start, stop,
        input  gen_rst, chirp_min_ctrl, chirp_max_ctrl,
        input  chirp_inc_rate, chirp_div_rate, chirp_delay,
        input  chirp_reverse, cur_profile, busy, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, num_profiles,
        input  burst_count, start, stop,
        output gen_rst, chirp_min_ctrl, chirp_max_ctrl,
        output chirp_inc_rate, chirp_div_rate, chirp_delay,
        output chirp_reverse, cur_profile, busy, done
    );
endinterface

// File: rtl/chirp_profile_sequencer.sv
// Steps a WaveGenerator through a table of chirp profiles,
// repeating the active list for a programmed number of bursts.
module chirp_profile_sequencer #(
    parameter int N  = 32,
    parameter int P  = 4,
    parameter int BW = 8
) (
    input logic                      clk,
    input logic                      rst,
    chirp_profile_sequencer_if.slave bus
);
    localparam int PW = $clog2(P);

    typedef enum logic [1:0] {
        S_IDLE, S_LOAD, S_RUN, S_DONE
    } state_t;

    state_t          r_state, w_nxt;
    logic [N-1:0]    r_min [P];
    logic [N-1:0]    r_max [P];
    logic [N-1:0]    r_inc [P];
    logic [N-1:0]    r_div [P];
    logic [N-1:0]    r_dwell [P];
    logic [7:0]      r_dly [P];
    logic            r_rev [P];

    logic [PW-1:0]   r_idx, w_idx;
    logic [BW-1:0]   r_rep, w_rep;
    logic [N-1:0]    r_cnt;
    logic [PW:0]     w_num;
    logic            w_more, w_last_rep;
    logic [PW-1:0]   w_pidx;
    logic [2:0]      w_fld;

    logic            r_gen_rst, r_busy, r_done;
    logic [N-1:0]    r_cmin, r_cmax, r_cinc, r_cdiv;
    logic [7:0]      r_cdly;
    logic            r_crev;
    logic [PW-1:0]   r_cur;

    assign w_pidx = bus.cfg_addr[PW+2:3];
    assign w_fld  = bus.cfg_addr[2:0];

    // Effective list length: 0 means one profile, oversize clamps to P.
    assign w_num = (bus.num_profiles == '0) ? (PW+1)'(1) :
                   (bus.num_profiles > (PW+1)'(P)) ? (PW+1)'(P) :
                   bus.num_profiles;
    assign w_more = ({1'b0, r_idx} < (w_num - (PW+1)'(1)));
    assign w_last_rep = (bus.burst_count != '0) &&
                        (r_rep == bus.burst_count - 1'b1);

    always_comb begin
        w_nxt = r_state;
        w_idx = r_idx;
        w_rep = r_rep;
        if (bus.stop) begin
            w_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (bus.start) begin
                    w_nxt = S_LOAD;
                    w_idx = '0;
                    w_rep = '0;
                end
                S_LOAD: w_nxt = S_RUN;
                S_RUN: if (r_cnt == N'(1)) begin
                    if (w_more) begin
                        w_idx = r_idx + 1'b1;
                        w_nxt = S_LOAD;
                    end else if (w_last_rep) begin
                        w_nxt = S_DONE;
                    end else begin
                        w_idx = '0;
                        w_rep = r_rep + 1'b1;
                        w_nxt = S_LOAD;
                    end
                end
                S_DONE: w_nxt = S_IDLE;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < P; i++) begin
                r_min[i]   <= '0;
                r_max[i]   <= '0;
                r_inc[i]   <= '0;
                r_div[i]   <= '0;
                r_dwell[i] <= '0;
                r_dly[i]   <= '0;
                r_rev[i]   <= 1'b0;
            end
        end else if (bus.cfg_we) begin
            unique case (1'b1)
                (w_fld == 3'd0): r_min[w_pidx] <= bus.cfg_wdata;
                (w_fld == 3'd1): r_max[w_pidx] <= bus.cfg_wdata;
                (w_fld == 3'd2): r_inc[w_pidx] <= bus.cfg_wdata;
                (w_fld == 3'd3): r_div[w_pidx] <= bus.cfg_wdata;
                (w_fld == 3'd4): begin
                    r_dly[w_pidx] <= bus.cfg_wdata[7:0];
                    r_rev[w_pidx] <= bus.cfg_wdata[8];
                end
                (w_fld == 3'd5): r_dwell[w_pidx] <= bus.cfg_wdata;
                default: ;
            endcase
        end
    end

    // Profile and dwell are snapshotted together on entry to LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_rep     <= '0;
            r_cnt     <= '0;
            r_gen_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cmin    <= '0;
            r_cmax    <= '0;
            r_cinc    <= '0;
            r_cdiv    <= '0;
            r_cdly    <= '0;
            r_crev    <= 1'b0;
            r_cur     <= '0;
        end else begin
            r_state   <= w_nxt;
            r_idx     <= w_idx;
            r_rep     <= w_rep;
            r_gen_rst <= (w_nxt != S_RUN);
            r_busy    <= (w_nxt == S_LOAD) || (w_nxt == S_RUN);
            r_done    <= (w_nxt == S_DONE);
            if (w_nxt == S_LOAD) begin
                r_cmin <= r_min[w_idx];
                r_cmax <= r_max[w_idx];
                r_cinc <= r_inc[w_idx];
                r_cdiv <= r_div[w_idx];
                r_cdly <= r_dly[w_idx];
                r_crev <= r_rev[w_idx];
                r_cur  <= w_idx;
                r_cnt  <= (r_dwell[w_idx] == '0) ? N'(1) : r_dwell[w_idx];
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.gen_rst        = r_gen_rst;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.chirp_min_ctrl = r_cmin;
    assign bus.chirp_max_ctrl = r_cmax;
    assign bus.chirp_inc_rate = r_cinc;
    assign bus.chirp_div_rate = r_cdiv;
    assign bus.chirp_delay    = r_cdly;
    assign bus.chirp_reverse  = r_crev;
    assign bus.cur_profile    = r_cur;
endmodule

// File: tb/tb_chirp_profile_sequencer.sv
// Randomized and directed bench for chirp_profile_sequencer against
// a slot-level behavioural model.
module tb_chirp_profile_sequencer;
    localparam int N  = 32;
    localparam int P  = 4;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    chirp_profile_sequencer_if #(.N(N), .P(P), .BW(BW)) bus ();

    chirp_profile_sequencer #(.N(N), .P(P), .BW(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the table plus a phase (0 idle, 1 playing a
    // slot, 2 done pulse) and the position inside the current slot.
    logic [N-1:0] t_min [P];
    logic [N-1:0] t_max [P];
    logic [N-1:0] t_inc [P];
    logic [N-1:0] t_div [P];
    logic [N-1:0] t_dw  [P];
    logic [8:0]   t_rd  [P];
    int ph, m_idx, m_rep, m_t, m_len;
    logic [N-1:0] e_min, e_max, e_inc, e_div;
    logic [7:0]   e_dly;
    logic         e_rev;
    int           e_cur;

    function automatic int eff(input int np);
        if (np == 0) return 1;
        if (np > P) return P;
        return np;
    endfunction

    task slot_begin();
        ph = 1;
        m_t = 0;
        m_len = 1 + ((t_dw[m_idx] == 0) ? 1 : int'(t_dw[m_idx]));
        e_min = t_min[m_idx];
        e_max = t_max[m_idx];
        e_inc = t_inc[m_idx];
        e_div = t_div[m_idx];
        e_dly = t_rd[m_idx][7:0];
        e_rev = t_rd[m_idx][8];
        e_cur = m_idx;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < P; i++) begin
                t_min[i] = 0; t_max[i] = 0; t_inc[i] = 0;
                t_div[i] = 0; t_dw[i] = 0; t_rd[i] = 0;
            end
            ph = 0; m_idx = 0; m_rep = 0; m_t = 0; m_len = 0;
            e_min = 0; e_max = 0; e_inc = 0; e_div = 0;
            e_dly = 0; e_rev = 0; e_cur = 0;
        end else begin
            if (bus.stop) begin
                ph = 0;
            end else if (ph == 0) begin
                if (bus.start) begin
                    m_idx = 0;
                    m_rep = 0;
                    slot_begin();
                end
            end else if (ph == 2) begin
                ph = 0;
            end else begin
                m_t++;
                if (m_t == m_len) begin
                    if (m_idx < eff(int'(bus.num_profiles)) - 1) begin
                        m_idx++;
                        slot_begin();
                    end else if (bus.burst_count != 0 &&
                                 m_rep == int'(bus.burst_count) - 1) begin
                        ph = 2;
                    end else begin
                        m_idx = 0;
                        m_rep = (m_rep + 1) % 256;
                        slot_begin();
                    end
                end
            end
            if (bus.cfg_we) begin
                case (int'(bus.cfg_addr[2:0]))
                    0: t_min[bus.cfg_addr[4:3]] = bus.cfg_wdata;
                    1: t_max[bus.cfg_addr[4:3]] = bus.cfg_wdata;
                    2: t_inc[bus.cfg_addr[4:3]] = bus.cfg_wdata;
                    3: t_div[bus.cfg_addr[4:3]] = bus.cfg_wdata;
                    4: t_rd[bus.cfg_addr[4:3]]  = bus.cfg_wdata[8:0];
                    5: t_dw[bus.cfg_addr[4:3]]  = bus.cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    int busy_cnt = 0;
    int done_cnt = 0;
    int nload = 0;
    int loads [0:4095];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", bus.busy, (ph == 1));
            chk("gen_rst", bus.gen_rst, !(ph == 1 && m_t > 0));
            chk("done", bus.done, (ph == 2));
            chk("min", bus.chirp_min_ctrl, e_min);
            chk("max", bus.chirp_max_ctrl, e_max);
            chk("inc", bus.chirp_inc_rate, e_inc);
            chk("div", bus.chirp_div_rate, e_div);
            chk("delay", bus.chirp_delay, e_dly);
            chk("reverse", bus.chirp_reverse, e_rev);
            chk("cur", bus.cur_profile, e_cur);
        end
        if (rst) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (bus.busy && bus.gen_rst && nload < 4096) begin
                loads[nload] = int'(bus.cur_profile);
                nload++;
            end
        end
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task wr(input int p, input int f, input logic [N-1:0] d);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = {p[1:0], f[2:0]};
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task set_prof(input int p, input logic [N-1:0] mn, input logic [N-1:0] mx,
                  input logic [N-1:0] inc, input logic [N-1:0] dv,
                  input int dly, input int rev, input int dw);
        wr(p, 0, mn);
        wr(p, 1, mx);
        wr(p, 2, inc);
        wr(p, 3, dv);
        wr(p, 4, N'((rev << 8) | dly));
        wr(p, 5, N'(dw));
    endtask

    task pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task wait_idle(input string nm, input int maxc);
        int c;
        c = 0;
        while ((bus.busy || bus.done) && c < maxc) begin
            tick();
            c++;
        end
        chk(nm, (c < maxc), 1'b1);
    endtask

    // seq holds expected profile indices, one nibble each, first is MS.
    task chk_seq(input string nm, input int l0, input int n,
                 input logic [31:0] seq);
        chk({nm, "_count"}, nload - l0, n);
        for (int i = 0; i < n; i++)
            chk(nm, loads[l0 + i], seq[4*(n-1-i) +: 4]);
    endtask

    int b0, d0, l0, c;

    initial begin
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
        bus.num_profiles = 1; bus.burst_count = 1;
        bus.start = 0; bus.stop = 0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rst_gen_rst", bus.gen_rst, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_min", bus.chirp_min_ctrl, 0);

        set_prof(0, 'h100, 'h800, 4, 1, 3, 0, 10);
        bus.num_profiles = 1; bus.burst_count = 1;
        b0 = busy_cnt; d0 = done_cnt;
        pulse_start();
        chk("t2_load_min", bus.chirp_min_ctrl, 'h100);
        chk("t2_load_gen_rst", bus.gen_rst, 1'b1);
        tick();
        chk("t2_run_gen_rst", bus.gen_rst, 1'b0);
        wait_idle("t2_timeout", 50);
        chk("t2_busy_cycles", busy_cnt - b0, 11);
        chk("t2_done", done_cnt - d0, 1);

        set_prof(0, 'h110, 'h900, 5, 2, 1, 1, 2);
        set_prof(1, 'h120, 'hA00, 6, 3, 2, 0, 5);
        set_prof(2, 'h130, 'hB00, 7, 4, 9, 1, 1);
        bus.num_profiles = 3; bus.burst_count = 2;
        b0 = busy_cnt; d0 = done_cnt; l0 = nload;
        pulse_start();
        wait_idle("t3_timeout", 100);
        chk_seq("t3_seq", l0, 6, 32'h012012);
        chk("t3_busy_cycles", busy_cnt - b0, 22);
        chk("t3_done", done_cnt - d0, 1);

        bus.burst_count = 0;
        d0 = done_cnt;
        pulse_start();
        c = 0;
        while (!(bus.cur_profile == 1 && !bus.gen_rst) && c < 100) begin
            tick(); c++;
        end
        chk("t4_reach", (c < 100), 1'b1);
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t4_busy", bus.busy, 1'b0);
        chk("t4_gen_rst", bus.gen_rst, 1'b1);
        repeat (4) tick();
        chk("t4_no_done", done_cnt - d0, 0);
        bus.num_profiles = 1; bus.burst_count = 1;
        pulse_start();
        chk("t4_restart_cur", bus.cur_profile, 0);
        wait_idle("t4_timeout", 50);

        wr(0, 5, 0);
        bus.num_profiles = 0;
        b0 = busy_cnt; l0 = nload;
        pulse_start();
        wait_idle("t5a_timeout", 20);
        chk("t5a_busy_cycles", busy_cnt - b0, 2);
        chk_seq("t5a_seq", l0, 1, 32'h0);

        set_prof(3, 'h140, 'hC00, 8, 5, 4, 0, 3);
        bus.num_profiles = 7;
        l0 = nload;
        pulse_start();
        wait_idle("t5b_timeout", 100);
        chk_seq("t5b_seq", l0, 4, 32'h0123);

        wr(1, 5, 1);
        bus.num_profiles = 2; bus.burst_count = 0;
        d0 = done_cnt; l0 = nload;
        pulse_start();
        c = 0;
        while (nload - l0 < 6 && c < 200) begin
            tick(); c++;
        end
        chk("t5c_reach", (c < 200), 1'b1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        repeat (3) tick();
        chk_seq("t5c_seq", l0, 6, 32'h010101);
        chk("t5c_no_done", done_cnt - d0, 0);

        wr(0, 5, 10);
        bus.num_profiles = 1; bus.burst_count = 2;
        pulse_start();
        tick();
        wr(0, 0, 'h200);
        chk("t6_hold_min", bus.chirp_min_ctrl, 'h110);
        c = 0;
        while (!bus.gen_rst && c < 50) begin
            tick(); c++;
        end
        chk("t6_reload_min", bus.chirp_min_ctrl, 'h200);
        wait_idle("t6_timeout", 50);

        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("t7_busy", bus.busy, 1'b0);
        tick();
        chk("t7_busy2", bus.busy, 1'b0);
        chk("t7_gen_rst", bus.gen_rst, 1'b1);

        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.cfg_we = 1'b1;
                bus.cfg_addr = 5'($urandom);
                bus.cfg_wdata = (bus.cfg_addr[2:0] == 3'd5) ?
                                N'($urandom_range(0, 5)) : N'($urandom);
            end else begin
                bus.cfg_we = 1'b0;
            end
            if ($urandom_range(0, 9) == 0)
                bus.num_profiles = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                bus.burst_count = 8'($urandom_range(0, 3));
            bus.start = ($urandom_range(0, 5) == 0);
            bus.stop = ($urandom_range(0, 24) == 0);
            if (it == 1500) begin
                #2 rst = 1'b0;
                #5 rst = 1'b1;
            end
            tick();
        end
        bus.cfg_we = 0; bus.start = 0; bus.stop = 1;
        tick();
        bus.stop = 0;
        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
